// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle RV32 core: opcodes, funct fields, FSM states, ALU ops.
package core_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB/SRA (funct7[5]) for the two funct3 codes that have a variant
  function automatic alu_op_e f3_to_op(logic [2:0] f3, logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational integer ALU for the multi-cycle core; shift amount width follows XLEN.
module core_alu
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  alu_op_e           alu_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   r
);

  localparam int unsigned SHW = (XLEN == 64) ? 6 : 5;

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    r = '0;
    case (alu_op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << shamt;
      ALU_SLT:  r = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: r = XLEN'(a < b);
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> shamt;
      ALU_SRA:  r = XLEN'($signed(a) >>> shamt);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle RV32 core: FETCH/DECODE/EXECUTE/WRITEBACK FSM with a handshaked instruction port.
// Define RV_ITYPE_EN to add the I-type ALU instructions (opcode 0010011).
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            zero_flag,
  output logic            retire,
  output logic            halted,
  output logic [XLEN-1:0] pc
);

  localparam int unsigned RIW = $clog2(NREGS);

  state_e          state_q, state_d;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, r_q, pc_q;
  logic [XLEN-1:0] a_d, b_d, alu_r;
  alu_op_e         op_q, op_d;
  logic            legal;
  logic [XLEN-1:0] rf [NREGS];

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  // Request is cut immediately by reset, even though the state register already reads FETCH
  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  // Decode: legality, ALU op and operand selection from the instruction register
  always_comb begin
    legal = 1'b0;
    op_d  = ALU_ADD;
    a_d   = (rs1 == 5'd0) ? '0 : rf[RIW'(rs1)];
    b_d   = (rs2 == 5'd0) ? '0 : rf[RIW'(rs2)];
    case (opcode)
      OP_R: begin
        op_d  = f3_to_op(f3, f7[5]);
        legal = (32'(rs1) < NREGS) && (32'(rs2) < NREGS) && (32'(rd) < NREGS) &&
                ((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
      end
`ifdef RV_ITYPE_EN
      OP_I: begin
        op_d  = f3_to_op(f3, (f3 == F3_SR) && f7[5]);
        b_d   = XLEN'($signed(ir_q[31:20]));
        legal = (32'(rs1) < NREGS) && (32'(rd) < NREGS) &&
                ((f3 == F3_SLL) ? (f7 == F7_BASE) :
                 (f3 == F3_SR)  ? ((f7 == F7_BASE) || (f7 == F7_ALT)) : 1'b1);
      end
`endif
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (imem_ack) state_d = DECODE;
      DECODE:    state_d = legal ? EXECUTE : HALT;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  core_alu #(.XLEN(XLEN)) u_alu (
    .alu_op (op_q),
    .a      (a_q),
    .b      (b_q),
    .r      (alu_r)
  );

  // Datapath registers; each state only touches its own stage's registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      op_q      <= ALU_ADD;
      pc_q      <= PC_RESET;
      zero_flag <= 1'b0;
      retire    <= 1'b0;
      halted    <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      retire <= (state_d == WRITEBACK);
      halted <= (state_d == HALT);
      case (state_q)
        FETCH: if (imem_ack) ir_q <= imem_rdata;
        DECODE: begin
          a_q  <= a_d;
          b_q  <= b_d;
          op_q <= op_d;
        end
        EXECUTE: begin
          r_q       <= alu_r;
          zero_flag <= (alu_r == '0);
        end
        WRITEBACK: begin
          if (rd != 5'd0) rf[RIW'(rd)] <= r_q;
          pc_q <= pc_q + XLEN'(4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed self-checking bench for multicycle_core with a retire scoreboard.
module tb_multicycle_core;

  localparam logic [31:0] PCR = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_ack, zero_flag, retire, halted;
  logic [31:0] imem_addr, imem_rdata, pc;
  logic        req2, ack2, zf2, ret2, halt2;
  logic [31:0] addr2, rdata2, pc2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        zf;
    logic [4:0]  rd;
    logic [31:0] val;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_core #(.XLEN(32), .NREGS(32), .PC_RESET(PCR)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .zero_flag(zero_flag),
    .retire(retire), .halted(halted), .pc(pc)
  );

  multicycle_core #(.XLEN(32), .NREGS(16)) dut_e (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .zero_flag(zf2),
    .retire(ret2), .halted(halt2), .pc(pc2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // One instruction expected to retire; the fetch is acknowledged after 'waits' idle cycles
  task automatic run_ok(input logic [31:0] ins, input int waits, input logic [4:0] rd,
                        input logic [31:0] val, input logic zf);
    exp_t        e;
    int          cyc;
    bit          done;
    logic [31:0] addr0;
    logic        zf_prev;
    sb.push_back('{pc: exp_pc, zf: zf, rd: rd, val: val, lat: waits + 4});
    addr0   = imem_addr;
    zf_prev = zero_flag;
    cyc     = 1;
    done    = 1'b0;
    chk("fetch_addr", imem_addr, exp_pc);
    while (!done && cyc < 40) begin
      imem_ack   = (cyc == waits + 1);
      imem_rdata = imem_ack ? ins : 32'hdead_beef;
      if (cyc <= waits + 1) begin
        chk("req_held", imem_req, 1'b1);
        chk("addr_stable", imem_addr, addr0);
      end
      tick();
      imem_ack = 1'b0;
      cyc++;
      if (cyc == waits + 3) chk("zf_hold", zero_flag, zf_prev);
      if (retire) begin
        done = 1'b1;
        e = sb.pop_front();
        chk("latency", cyc, e.lat);
        chk("zero_flag", zero_flag, e.zf);
        chk("pc_at_retire", pc, e.pc);
        chk("rf_value", dut.rf[e.rd], e.val);
      end
    end
    chk("retired", done, 1'b1);
    if (!done) sb.delete();
    tick();
    chk("retire_pulse", retire, 1'b0);
    chk("next_req", imem_req, 1'b1);
    chk("pc_next", pc, exp_pc + 32'd4);
    exp_pc = exp_pc + 32'd4;
  endtask

  // One instruction expected to stop the core without retiring
  task automatic run_halt(input logic [31:0] ins, input int waits);
    int cyc;
    bit ret_seen;
    cyc      = 1;
    ret_seen = 1'b0;
    while (!halted && cyc < 40) begin
      imem_ack   = (cyc == waits + 1);
      imem_rdata = imem_ack ? ins : 32'hdead_beef;
      tick();
      imem_ack = 1'b0;
      cyc++;
      if (retire) ret_seen = 1'b1;
    end
    chk("halt_seen", halted, 1'b1);
    chk("halt_latency", cyc, waits + 3);
    chk("halt_pc", pc, exp_pc);
    chk("halt_req", imem_req, 1'b0);
    imem_ack   = 1'b1;
    imem_rdata = r_ins(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (retire) ret_seen = 1'b1;
    end
    imem_ack = 1'b0;
    chk("halt_no_retire", ret_seen, 1'b0);
    chk("halt_frozen_pc", pc, exp_pc);
    chk("halt_still", halted, 1'b1);
    chk("halt_req_low", imem_req, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    ack2       = 1'b0;
    rdata2     = '0;
    exp_pc     = PCR;
    tick();
    tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, PCR);
    chk("rst_retire", retire, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_zf", zero_flag, 1'b0);
    reset = 1'b0;
    #1;
    chk("req_after_rst", imem_req, 1'b1);

    run_ok(r_ins(7'd0, 5'd1, 5'd1, 3'b000, 5'd2), 0, 5'd2, 32'd0, 1'b1);
    run_ok(r_ins(7'h20, 5'd1, 5'd1, 3'b000, 5'd3), 3, 5'd3, 32'd0, 1'b1);
    run_ok(r_ins(7'd0, 5'd0, 5'd0, 3'b110, 5'd5), 1, 5'd5, 32'd0, 1'b1);
`ifdef RV_ITYPE_EN
    run_ok(i_ins(12'd5, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'd5, 1'b0);
    run_ok(r_ins(7'd0, 5'd1, 5'd1, 3'b000, 5'd2), 0, 5'd2, 32'd10, 1'b0);
    run_ok(r_ins(7'h20, 5'd1, 5'd1, 3'b000, 5'd3), 0, 5'd3, 32'd0, 1'b1);
    run_ok(r_ins(7'd0, 5'd1, 5'd1, 3'b000, 5'd0), 0, 5'd0, 32'd0, 1'b0);
    run_ok(i_ins(12'hff8, 5'd0, 3'b000, 5'd4), 0, 5'd4, 32'hffff_fff8, 1'b0);
    run_ok(i_ins(12'd1, 5'd0, 3'b000, 5'd6), 0, 5'd6, 32'd1, 1'b0);
    run_ok(r_ins(7'h20, 5'd6, 5'd4, 3'b101, 5'd5), 0, 5'd5, 32'hffff_fffc, 1'b0);
    run_ok(r_ins(7'd0, 5'd6, 5'd4, 3'b101, 5'd7), 2, 5'd7, 32'h7fff_fffc, 1'b0);
    run_ok(r_ins(7'd0, 5'd1, 5'd4, 3'b010, 5'd8), 0, 5'd8, 32'd1, 1'b0);
    run_ok(r_ins(7'd0, 5'd1, 5'd4, 3'b011, 5'd9), 0, 5'd9, 32'd0, 1'b1);
    run_ok(i_ins(12'h402, 5'd4, 3'b101, 5'd10), 0, 5'd10, 32'hffff_fffe, 1'b0);
    run_halt(i_ins(12'h202, 5'd4, 3'b101, 5'd11), 0);
    chk("bad_srai_rd", dut.rf[11], 32'd0);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    exp_pc = PCR;
    #1;
`endif
    run_halt(r_ins(7'd1, 5'd1, 5'd1, 3'b000, 5'd2), 1);

    // Reset lands in FETCH while the memory is acknowledging
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    exp_pc     = PCR;
    imem_ack   = 1'b1;
    imem_rdata = r_ins(7'h20, 5'd0, 5'd0, 3'b000, 5'd7);
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_req_drop", imem_req, 1'b0);
    tick();
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("rst_mid_pc", pc, PCR);
    chk("rst_mid_req", imem_req, 1'b1);
    chk("rst_mid_zf", zero_flag, 1'b0);
    chk("rst_mid_halted", halted, 1'b0);
    chk("rst_mid_retire", retire, 1'b0);
    chk("rst_mid_ir", dut.ir_q, 32'd0);

`ifdef RV_ITYPE_EN
    run_ok(i_ins(12'd1, 5'd0, 3'b000, 5'd1), 0, 5'd1, 32'd1, 1'b0);
`else
    run_halt(i_ins(12'd1, 5'd0, 3'b000, 5'd1), 0);
    chk("itype_off_x1", dut.rf[1], 32'd0);
`endif

    // RV32E instance: legal x15 access, then x20 must halt
    chk("e_req", req2, 1'b1);
    ack2   = 1'b1;
    rdata2 = r_ins(7'd0, 5'd0, 5'd0, 3'b000, 5'd15);
    tick();
    ack2 = 1'b0;
    tick();
    tick();
    chk("e_retire", ret2, 1'b1);
    tick();
    chk("e_pc", pc2, 32'd4);
    ack2   = 1'b1;
    rdata2 = r_ins(7'd0, 5'd2, 5'd1, 3'b000, 5'd20);
    tick();
    ack2 = 1'b0;
    tick();
    tick();
    chk("e_halted", halt2, 1'b1);
    chk("e_retire_none", ret2, 1'b0);
    chk("e_halt_pc", pc2, 32'd4);
    chk("e_halt_req", req2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
